// File: rtl/adc_sample_feeder.sv
// -----------------------------------------------------------------------------
// adc_sample_feeder
//
// Buffers raw ADC converter samples in a FIFO and replays them to the
// correlator channels as single-cycle pushADC pulses. The ADC word is held
// between pulses. Consecutive pushes are never closer than
// max(Feed_Gap, MIN_GAP) cycles.
//
// Optional feature: define FEED_OFFSET_EN to add the Feed_Offset register at
// 0x0120. Each FIFO output then becomes sample - offset, saturated to 16 bits.
// The latency to ADC is the same with or without the feature.
//
// Ports
//   clk         single clock, rising edge
//   rst         asynchronous, active-low reset
//   adc_data    two's-complement converter sample
//   adc_strobe  adc_data valid this cycle (converter cannot be stalled)
//   addr        bus address, [15:0] decoded
//   Wdata       bus write data
//   write       bus write strobe
//   read        bus read strobe
//   Rdata_feed  combinational read data, 0 when idle or unmapped
//   ADC         sample to the channels, held between pushes
//   pushADC     one-cycle pulse, ADC valid
//   overflow    mirror of the sticky overflow flag (Feed_Status[16])
//
// Register map
//   0x0110 Feed_Control  [0] enable, [1] flush (write-1, self-clearing, reads 0)
//   0x0114 Feed_Status   [8:0] level, [16] overflow (write 1 to clear)
//   0x0118 Feed_Gap      [7:0] push spacing
//   0x011C Drop_Count    read-only; any write clears it
//   0x0120 Feed_Offset   signed 16b (only when FEED_OFFSET_EN is defined)
// -----------------------------------------------------------------------------
module adc_sample_feeder #(
  parameter int DEPTH   = 16,
  parameter int MIN_GAP = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] adc_data,
  input  logic        adc_strobe,
  input  logic [31:0] addr,
  input  logic [31:0] Wdata,
  input  logic        write,
  input  logic        read,
  output logic [31:0] Rdata_feed,
  output logic [15:0] ADC,
  output logic        pushADC,
  output logic        overflow
);

  localparam int          DATA_W    = 16;
  localparam int          AW        = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL  = (AW+1)'(DEPTH);
  localparam logic [7:0]  MIN_GAP_L = 8'(MIN_GAP);

  localparam logic [15:0] A_CTRL = 16'h0110;
  localparam logic [15:0] A_STAT = 16'h0114;
  localparam logic [15:0] A_GAP  = 16'h0118;
  localparam logic [15:0] A_DROP = 16'h011C;
  localparam logic [15:0] A_OFF  = 16'h0120;

  typedef enum logic [1:0] {IDLE, PUSH, GAP} state_t;

  state_t                   state;
  logic signed [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]              wr_ptr;
  logic [AW:0]              rd_ptr;
  logic [AW:0]              level;
  logic [8:0]               level9;
  logic                     enable;
  logic [7:0]               gap_reg;
  logic [7:0]               gap_cnt;
  logic [7:0]               gap_eff;
  logic [31:0]              drop_count;
  logic [15:0]              reg_addr;
  logic                     ctrl_wr, stat_wr, gap_wr, drop_wr;
  logic                     flush, full, pop, wr_en, drop;
  logic signed [DATA_W-1:0] fifo_out_p0;
  logic signed [DATA_W-1:0] sample_p0;
  logic                     unused;

  assign unused   = ^{addr[31:16], Wdata};
  assign reg_addr = addr[15:0];

  assign ctrl_wr  = write && (reg_addr == A_CTRL);
  assign stat_wr  = write && (reg_addr == A_STAT);
  assign gap_wr   = write && (reg_addr == A_GAP);
  assign drop_wr  = write && (reg_addr == A_DROP);
  assign flush    = ctrl_wr && Wdata[1];

  // Pointers carry one extra bit, so level can tell full from empty.
  assign level    = wr_ptr - rd_ptr;
  assign level9   = 9'(level);
  assign full     = (level == FULL_LVL);

  // A pop in PUSH frees a slot in the same cycle, so a strobe into a full
  // FIFO is still accepted when it coincides with a pop.
  assign pop      = (state == PUSH) && (level != '0);
  assign wr_en    = adc_strobe && enable && !flush && (!full || pop);
  assign drop     = adc_strobe && enable && !flush && full && !pop;

  assign gap_eff  = (gap_reg < MIN_GAP_L) ? MIN_GAP_L : gap_reg;

  assign fifo_out_p0 = mem[rd_ptr[AW-1:0]];

`ifdef FEED_OFFSET_EN
  logic signed [DATA_W-1:0] offset;

  function automatic logic signed [DATA_W-1:0] sat16(input logic signed [DATA_W:0] v);
    if (v > 17'sd32767)
      return 16'sh7FFF;
    else if (v < -17'sd32768)
      return 16'sh8000;
    else
      return v[DATA_W-1:0];
  endfunction

  assign sample_p0 = sat16($signed({fifo_out_p0[DATA_W-1], fifo_out_p0})
                         - $signed({offset[DATA_W-1], offset}));
`else
  assign sample_p0 = fifo_out_p0;
`endif

  // Register read mux. A write cycle returns nothing.
  always_comb begin
    Rdata_feed = '0;
    if (read && !write) begin
      case (reg_addr)
        A_CTRL:  Rdata_feed = {31'b0, enable};
        A_STAT:  Rdata_feed = {15'b0, overflow, 7'b0, level9};
        A_GAP:   Rdata_feed = {24'b0, gap_reg};
        A_DROP:  Rdata_feed = drop_count;
`ifdef FEED_OFFSET_EN
        A_OFF:   Rdata_feed = {16'b0, offset};
`endif
        default: Rdata_feed = '0;
      endcase
    end
  end

  // FIFO storage (data only, not reset)
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr[AW-1:0]] <= $signed(adc_data);
  end

  // Registers, pointers and drop accounting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      enable     <= 1'b0;
      gap_reg    <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
`ifdef FEED_OFFSET_EN
      offset     <= '0;
`endif
    end else begin
      if (ctrl_wr)
        enable <= Wdata[0];
      if (gap_wr)
        gap_reg <= Wdata[7:0];
`ifdef FEED_OFFSET_EN
      if (write && (reg_addr == A_OFF))
        offset <= $signed(Wdata[15:0]);
`endif
      if (drop_wr)
        drop_count <= '0;
      else if (drop && (drop_count != '1))
        drop_count <= drop_count + 32'd1;
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop)
        overflow <= 1'b1;
      else if (stat_wr && Wdata[16])
        overflow <= 1'b0;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_en)
          wr_ptr <= wr_ptr + 1'b1;
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Push pacing FSM
  // A push happens on the clock edge that leaves PUSH. gap_cnt is loaded with
  // G-1 there. The FSM then decides on the edge where gap_cnt runs from 1 to 0,
  // so the next push lands exactly G cycles later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      gap_cnt <= '0;
      ADC     <= '0;
      pushADC <= 1'b0;
    end else begin
      pushADC <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && (level != '0))
            state <= PUSH;
        end
        PUSH: begin
          // A flush may have emptied the FIFO after the decision was made.
          if (level != '0) begin
            ADC     <= sample_p0;
            pushADC <= 1'b1;
            gap_cnt <= gap_eff - 8'd1;
            state   <= GAP;
          end else begin
            state <= IDLE;
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt - 8'd1;
          if (gap_cnt <= 8'd1)
            state <= (enable && (level != '0)) ? PUSH : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
